// File: rtl/log_div_lut_loader.sv
// Streams host-supplied log2/exp2 table entries through a small FIFO into the
// divider's LUT write port, producing exactly LUT_SIZE ordered write beats.
module log_div_lut_loader #(
  parameter int FLOAT_LEN  = 16,
  parameter int MANT_LEN   = 10,
  parameter int LUT_SIZE   = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MANT_LEN-1:0]  in_log2,
  input  logic [FLOAT_LEN-1:0] in_exp2,
  output logic                 lut_wr_en,
  output logic [MANT_LEN-1:0]  log2_lut_data_in,
  output logic [FLOAT_LEN-1:0] exp2_lut_data_in,
  output logic                 busy,
  output logic                 lut_ready
);

  localparam int CNT_W = $clog2(LUT_SIZE) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = MANT_LEN + FLOAT_LEN;
  localparam logic [CNT_W-1:0] LUT_SIZE_C  = CNT_W'(LUT_SIZE);
  localparam logic [CNT_W-1:0] LAST_BEAT_C = CNT_W'(LUT_SIZE - 1);
  localparam logic [OCC_W-1:0] DEPTH_C     = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]     sent_cnt_q, sent_cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic                 lut_wr_en_q, lut_wr_en_d;
  logic [MANT_LEN-1:0]  log2_q, log2_d;
  logic [FLOAT_LEN-1:0] exp2_q, exp2_d;
  logic                 busy_q, busy_d;
  logic                 lut_ready_q, lut_ready_d;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];

  logic fifo_full_s;
  logic fifo_empty_s;
  logic in_ready_s;
  logic push_s;
  logic pop_s;

  assign fifo_full_s  = (occ_q == DEPTH_C);
  assign fifo_empty_s = (occ_q == {OCC_W{1'b0}});
  assign in_ready_s   = (state_q == S_LOAD) && !fifo_full_s && (acc_cnt_q < LUT_SIZE_C);
  assign push_s       = in_valid && in_ready_s;
  assign pop_s        = (state_q == S_LOAD) && !fifo_empty_s && (sent_cnt_q < LUT_SIZE_C);

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    wait_cnt_d  = wait_cnt_q;
    lut_wr_en_d = 1'b0;
    log2_d      = log2_q;
    exp2_d      = exp2_q;
    busy_d      = busy_q;
    lut_ready_d = lut_ready_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          acc_cnt_d  = {CNT_W{1'b0}};
          sent_cnt_d = {CNT_W{1'b0}};
          wr_ptr_d   = {PTR_W{1'b0}};
          rd_ptr_d   = {PTR_W{1'b0}};
          occ_d      = {OCC_W{1'b0}};
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (push_s) begin
          wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end else begin
          wr_ptr_d  = wr_ptr_q;
        end
        if (pop_s) begin
          rd_ptr_d         = rd_ptr_q + PTR_W'(1);
          sent_cnt_d       = sent_cnt_q + CNT_W'(1);
          {log2_d, exp2_d} = mem_q[rd_ptr_q];
          lut_wr_en_d      = 1'b1;
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
          occ_d = occ_q + OCC_W'(1);
        end else if (pop_s && !push_s) begin
          occ_d = occ_q - OCC_W'(1);
        end else begin
          occ_d = occ_q;
        end
        // Leave LOAD at the same edge that registers the final beat
        if (pop_s && (sent_cnt_q == LAST_BEAT_C)) begin
          state_d    = S_WAIT;
          wait_cnt_d = 2'd0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WAIT: begin
        // Covers the divider's sample of the final beat plus its pointer update
        // and write-done registration before the tables are declared usable.
        if (wait_cnt_q == 2'd2) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          lut_ready_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        lut_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_cnt_q   <= {CNT_W{1'b0}};
      sent_cnt_q  <= {CNT_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      occ_q       <= {OCC_W{1'b0}};
      wait_cnt_q  <= 2'd0;
      lut_wr_en_q <= 1'b0;
      log2_q      <= {MANT_LEN{1'b0}};
      exp2_q      <= {FLOAT_LEN{1'b0}};
      busy_q      <= 1'b0;
      lut_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      wait_cnt_q  <= wait_cnt_d;
      lut_wr_en_q <= lut_wr_en_d;
      log2_q      <= log2_d;
      exp2_q      <= exp2_d;
      busy_q      <= busy_d;
      lut_ready_q <= lut_ready_d;
    end
  end

  // Entry storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_log2, in_exp2};
    end
  end

  assign in_ready         = in_ready_s;
  assign lut_wr_en        = lut_wr_en_q;
  assign log2_lut_data_in = log2_q;
  assign exp2_lut_data_in = exp2_q;
  assign busy             = busy_q;
  assign lut_ready        = lut_ready_q;

endmodule
